aud_sram_ctrl: RTL and testbench
================================

AUD_SRAM_CTRL -- requirements
Module: aud_sram_ctrl

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, write-FIFO entries; ADDR_W, default 20, SRAM word address width; DATA_W, default 16, sample width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- i_clk  in  1  single clock, all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_wr_valid  in  1  one-cycle write pulse from the AudRecorder stage upstream.
- i_wr_addr  in  ADDR_W  write word address, qualified by i_wr_valid.
- i_wr_data  in  DATA_W  write sample, qualified by i_wr_valid.
- o_overflow  out  1  sticky flag: a write was dropped.
- o_fifo_level  out  3  current FIFO occupancy, 0..DEPTH.
- i_rd_req  in  1  one-cycle read request pulse.
- i_rd_addr  in  ADDR_W  read word address, qualified by i_rd_req.
- o_rd_ready  out  1  read request can be accepted this cycle.
- o_rd_data  out  DATA_W  read result.
- o_rd_valid  out  1  one-cycle pulse; o_rd_data is valid.
- o_SRAM_ADDR  out  ADDR_W  SRAM address.
- io_SRAM_DQ  inout  DATA_W  SRAM data bus.
- o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_CE_N  out  1 each  active-low SRAM strobes.
- o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  byte enables, tied 0.

Function
REQ-003 SHALL push {i_wr_addr, i_wr_data} into the FIFO on every edge where i_wr_valid=1, except as limited by REQ-004.
- A pushed entry SHALL be visible to the FSM on the next cycle.
REQ-004 When the FIFO is full and no pop occurs on the same edge, a push SHALL be dropped and o_overflow SHALL be set; o_overflow stays set until reset.
- A push and a pop on the same edge SHALL both take effect, and o_fifo_level SHALL be unchanged.
REQ-005 Read handshake:
- o_rd_ready SHALL equal (no read pending) AND (FSM not in R0/R1).
- i_rd_req with o_rd_ready=1 SHALL latch i_rd_addr as the pending read.
- i_rd_req with o_rd_ready=0 SHALL be ignored.
REQ-006 The FSM SHALL have states IDLE, W0, W1, R0, R1. From IDLE, evaluated each edge:
- Read pending and o_fifo_level != DEPTH -> R0.
- Otherwise, o_fifo_level != 0 -> W0, popping the FIFO head on that edge.
- Otherwise, stay in IDLE.
- A read request sampled on the same edge SHALL count as pending for this decision.
REQ-007 W0 SHALL last 1 cycle with: o_SRAM_ADDR = entry address, io_SRAM_DQ driven with entry data, WE_N=0, CE_N=0, OE_N=1.
REQ-008 W1 SHALL last 1 cycle with: address and DQ held, WE_N=1, CE_N=0; the FSM then returns to IDLE.
REQ-009 R0 SHALL last 1 cycle with: o_SRAM_ADDR = pending address, DQ high-Z, OE_N=0, CE_N=0, WE_N=1.
REQ-010 R1 SHALL keep the R0 strobes and capture io_SRAM_DQ into o_rd_data on the edge leaving R1.
- o_rd_valid=1 for exactly the following cycle.
- The pending read clears on that edge, and the FSM returns to IDLE.
REQ-011 Read latency SHALL be fixed: i_rd_req accepted in cycle c with the FSM idle and FIFO not full gives R0 at c+1, R1 at c+2, o_rd_valid at c+3.
REQ-012 Write latency SHALL be fixed: i_wr_valid in cycle c with the FIFO empty and FSM idle gives WE_N=0 at c+2.
REQ-013 Outside W0/W1, io_SRAM_DQ SHALL be high-Z.
REQ-014 Outside W0/W1/R0/R1, WE_N, OE_N and CE_N SHALL all be 1.
REQ-015 o_SRAM_ADDR SHALL hold its last value while in IDLE.
REQ-016 Reads SHALL NOT be forwarded from the FIFO: a read of an address still queued returns the current SRAM content.
REQ-017 o_rd_data SHALL hold its value until the next capture.
REQ-018 Back-to-back operations SHALL be allowed: IDLE is occupied for exactly 1 cycle between consecutive accesses.

Reset
REQ-019 While i_rst=1 at an edge, the block SHALL reset to:
- FSM = IDLE, FIFO empty, o_fifo_level=0, o_overflow=0.
- Read pending cleared, o_rd_valid=0, o_rd_data=0, o_rd_ready=1.
- o_SRAM_ADDR=0, WE_N=OE_N=CE_N=1, DQ high-Z.
REQ-020 Reset asserted during W0/W1/R0/R1 SHALL abort the access on that edge.
- No o_rd_valid SHALL follow the aborted access.
- Queued entries SHALL be discarded.

Verification
REQ-021 Single write: i_wr_valid with addr 0x00005, data 0xA5A5 in cycle 10 -> WE_N=0 in cycle 12 with ADDR=0x00005 and DQ=0xA5A5; WE_N=1 in cycle 13; IDLE in cycle 14.
REQ-022 Read-back: after REQ-021 completes, i_rd_req for addr 0x00005 (SRAM model returns 0xA5A5) -> o_rd_valid exactly 3 cycles after the request, with o_rd_data=0xA5A5.
REQ-023 Overflow, DEPTH=4:
- Stimulus: a read held in R0/R1 while 6 writes arrive on consecutive cycles.
- Required: o_fifo_level saturates at 4, o_overflow=1, and only the first 4 entries (plus any accepted on a pop edge) reach the SRAM, in order.
REQ-024 Simultaneous events:
- i_wr_valid and i_rd_req in the same cycle with the FIFO empty -> read serviced first (R0 next cycle), write follows from IDLE.
- The same collision with the FIFO full -> write serviced first.
- i_rd_req while o_rd_ready=0 -> no response.
REQ-025 Mid-operation reset: i_rst=1 during W0 -> WE_N=1 and DQ high-Z on the next cycle, o_fifo_level=0, o_overflow=0; no further SRAM strobes without new stimulus.
REQ-026 Recorder-rate stream: 10 writes spaced 40 cycles apart to addresses 0..9 -> every sample written in order, and o_overflow remains 0.

Source files
------------

// File: rtl/aud_sram_ctrl_if.sv
// aud_sram_ctrl_if: recorder write port, read port and SRAM strobes.
// The SRAM data bus is bidirectional and stays a plain module port.
interface aud_sram_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic              i_wr_valid;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_overflow;
  logic [2:0]        o_fifo_level;

  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_ready;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;

  logic [ADDR_W-1:0] o_SRAM_ADDR;
  logic              o_SRAM_WE_N;
  logic              o_SRAM_OE_N;
  logic              o_SRAM_CE_N;
  logic              o_SRAM_LB_N;
  logic              o_SRAM_UB_N;

  modport master (
    output i_wr_valid,
    output i_wr_addr,
    output i_wr_data,
    input  o_overflow,
    input  o_fifo_level,
    output i_rd_req,
    output i_rd_addr,
    input  o_rd_ready,
    input  o_rd_data,
    input  o_rd_valid,
    input  o_SRAM_ADDR,
    input  o_SRAM_WE_N,
    input  o_SRAM_OE_N,
    input  o_SRAM_CE_N,
    input  o_SRAM_LB_N,
    input  o_SRAM_UB_N
  );

  modport slave (
    input  i_wr_valid,
    input  i_wr_addr,
    input  i_wr_data,
    output o_overflow,
    output o_fifo_level,
    input  i_rd_req,
    input  i_rd_addr,
    output o_rd_ready,
    output o_rd_data,
    output o_rd_valid,
    output o_SRAM_ADDR,
    output o_SRAM_WE_N,
    output o_SRAM_OE_N,
    output o_SRAM_CE_N,
    output o_SRAM_LB_N,
    output o_SRAM_UB_N
  );

endinterface

// File: rtl/aud_sram_ctrl.sv
// aud_sram_ctrl: async-style SRAM controller with a small write FIFO
// for recorder samples and a single-outstanding read port.
module aud_sram_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  aud_sram_ctrl_if.slave    bus,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] FULL = 3'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    W0,
    W1,
    R0,
    R1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo [DEPTH];
  entry_t            head;
  entry_t            in_ent;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [2:0]        level;
  logic              overflow;

  state_t            state;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] rd_addr_eff;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;
  logic              we_n;
  logic              oe_n;
  logic              ce_n;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              rd_ready;
  logic              rd_take;
  logic              rd_go;
  logic              pop;
  logic              push;
  logic              wr_busy;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign head    = fifo[rd_ptr];
  assign in_ent  = '{addr: bus.i_wr_addr,
                     data: bus.i_wr_data};

  assign rd_ready = !pend &&
                    (state != R0) &&
                    (state != R1);
  assign rd_take  = bus.i_rd_req && rd_ready;

  // A request arriving on this edge already
  // counts as pending for the IDLE decision.
  assign rd_go = (state == IDLE) &&
                 (pend || rd_take) &&
                 (level != FULL);
  assign pop   = (state == IDLE) &&
                 !rd_go &&
                 (level != 3'd0);

  // When full, a push still fits if the head
  // leaves on the same edge.
  assign push    = bus.i_wr_valid &&
                   ((level != FULL) || pop);
  assign wr_busy = bus.i_wr_valid && !push;

  assign rd_addr_eff = pend ? pend_addr
                            : bus.i_rd_addr;

  // FIFO storage; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo[wr_ptr] <= in_ent;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
      if (wr_busy) begin
        overflow <= 1'b1;
      end
    end
  end

  // Access sequencer with registered SRAM strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      pend      <= 1'b0;
      pend_addr <= '0;
      sram_addr <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      we_n      <= 1'b1;
      oe_n      <= 1'b1;
      ce_n      <= 1'b1;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_take) begin
        pend      <= 1'b1;
        pend_addr <= bus.i_rd_addr;
      end
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            rd_go: begin
              state     <= R0;
              sram_addr <= rd_addr_eff;
              oe_n      <= 1'b0;
              ce_n      <= 1'b0;
            end
            pop: begin
              state     <= W0;
              sram_addr <= head.addr;
              dq_out    <= head.data;
              dq_oe     <= 1'b1;
              we_n      <= 1'b0;
              ce_n      <= 1'b0;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        W0: begin
          state <= W1;
          we_n  <= 1'b1;
        end
        W1: begin
          state <= IDLE;
          ce_n  <= 1'b1;
          dq_oe <= 1'b0;
        end
        R0: begin
          state <= R1;
        end
        R1: begin
          state    <= IDLE;
          rd_data  <= io_SRAM_DQ;
          rd_valid <= 1'b1;
          pend     <= 1'b0;
          oe_n     <= 1'b1;
          ce_n     <= 1'b1;
        end
        default: begin
          state <= IDLE;
          dq_oe <= 1'b0;
          we_n  <= 1'b1;
          oe_n  <= 1'b1;
          ce_n  <= 1'b1;
        end
      endcase
    end
  end

  assign io_SRAM_DQ = dq_oe ? dq_out
                            : {DATA_W{1'bz}};

  assign bus.o_overflow   = overflow;
  assign bus.o_fifo_level = level;
  assign bus.o_rd_ready   = rd_ready;
  assign bus.o_rd_data    = rd_data;
  assign bus.o_rd_valid   = rd_valid;
  assign bus.o_SRAM_ADDR  = sram_addr;
  assign bus.o_SRAM_WE_N  = we_n;
  assign bus.o_SRAM_OE_N  = oe_n;
  assign bus.o_SRAM_CE_N  = ce_n;
  assign bus.o_SRAM_LB_N  = 1'b0;
  assign bus.o_SRAM_UB_N  = 1'b0;

endmodule

// File: tb/tb_aud_sram_ctrl.sv
// tb_aud_sram_ctrl: SRAM model plus write/read scoreboards,
// a vector table and timed sequences for the corner cases.
module tb_aud_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] dq;
  logic [15:0] mem [64];

  int n_chk;
  int n_pass;
  int strobes;

  typedef struct {
    logic [19:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [19:0] waddr;
    logic [15:0] wdata;
    logic [19:0] raddr;
    logic [15:0] rexp;
  } vec_t;

  wr_t         wrq [$];
  logic [15:0] rdq [$];
  vec_t        tbl [4];

  aud_sram_ctrl_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  aud_sram_ctrl #(
    .DEPTH (4),
    .ADDR_W(20),
    .DATA_W(16)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .io_SRAM_DQ(dq)
  );

  always #5 clk = ~clk;

  assign dq = (bus.o_SRAM_OE_N == 1'b0 &&
               bus.o_SRAM_CE_N == 1'b0)
              ? mem[bus.o_SRAM_ADDR[5:0]]
              : 16'bz;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h",
                  nm, act, exp);
  endtask

  function automatic logic dq_idle();
    return (dq === 16'hzzzz) || (dq === 16'h0000);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_wr(input logic [19:0] a,
                          input logic [15:0] d);
    wrq.push_back('{a: a, d: d});
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = a;
    bus.i_wr_data  = d;
    tick(1);
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic pulse_rd(input logic [19:0] a,
                          input logic [15:0] e);
    rdq.push_back(e);
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = a;
    tick(1);
    bus.i_rd_req = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < n && wrq.size() != 0; i++)
      tick(1);
    chk("wr_drain", wrq.size(), 0);
  endtask

  task automatic wait_rd(input int n);
    for (int i = 0; i < n && rdq.size() != 0; i++)
      tick(1);
    chk("rd_drain", rdq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t, limit 100000",
             $time);
    $fatal(1);
  end

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    strobes = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[7]     = 16'h1111;
    mem[6'h30] = 16'hBEEF;
    mem[6'h31] = 16'hCAFE;

    tbl[0] = '{20'h00010, 16'h1234, 20'h00010, 16'h1234};
    tbl[1] = '{20'hFFFFF, 16'hFFFF, 20'hFFFFF, 16'hFFFF};
    tbl[2] = '{20'h00021, 16'h0001, 20'h00010, 16'h1234};
    tbl[3] = '{20'h0002A, 16'h8000, 20'h00007, 16'h1111};

    rst            = 1'b1;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    bus.i_rd_req   = 1'b0;
    bus.i_rd_addr  = '0;

    fork
      forever begin
        @(negedge clk);
        if (bus.o_SRAM_WE_N === 1'b0) begin
          if (wrq.size() == 0) begin
            chk("wr_unexpected", wrq.size(), 1);
          end else begin
            wr_t e;
            e = wrq.pop_front();
            chk("wr_addr", 32'(bus.o_SRAM_ADDR), 32'(e.a));
            chk("wr_data", 32'(dq), 32'(e.d));
            chk("wr_oe_n", 32'(bus.o_SRAM_OE_N), 1);
            mem[bus.o_SRAM_ADDR[5:0]] = dq;
          end
        end
        if (bus.o_rd_valid === 1'b1) begin
          if (rdq.size() == 0) begin
            chk("rd_unexpected", rdq.size(), 1);
          end else begin
            logic [15:0] e;
            e = rdq.pop_front();
            chk("rd_data", 32'(bus.o_rd_data), 32'(e));
          end
        end
      end
    join_none

    // reset state, sampled while reset is held
    tick(3);
    chk("rst_level", 32'(bus.o_fifo_level), 0);
    chk("rst_ovf", 32'(bus.o_overflow), 0);
    chk("rst_ready", 32'(bus.o_rd_ready), 1);
    chk("rst_valid", 32'(bus.o_rd_valid), 0);
    chk("rst_rdata", 32'(bus.o_rd_data), 0);
    chk("rst_addr", 32'(bus.o_SRAM_ADDR), 0);
    chk("rst_strb", 32'({bus.o_SRAM_WE_N, bus.o_SRAM_OE_N,
                          bus.o_SRAM_CE_N}), 32'h7);
    chk("rst_bytes", 32'({bus.o_SRAM_LB_N,
                           bus.o_SRAM_UB_N}), 0);
    chk("rst_dq_z", 32'(dq_idle()), 1);
    rst = 1'b0;
    tick(2);

    // single write: W0 two cycles after the pulse
    pulse_wr(20'h00005, 16'hA5A5);
    chk("w_level1", 32'(bus.o_fifo_level), 1);
    tick(1);
    chk("w0_we_n", 32'(bus.o_SRAM_WE_N), 0);
    chk("w0_ce_n", 32'(bus.o_SRAM_CE_N), 0);
    chk("w0_addr", 32'(bus.o_SRAM_ADDR), 32'h5);
    chk("w0_dq", 32'(dq), 32'hA5A5);
    tick(1);
    chk("w1_we_n", 32'(bus.o_SRAM_WE_N), 1);
    chk("w1_ce_n", 32'(bus.o_SRAM_CE_N), 0);
    chk("w1_dq", 32'(dq), 32'hA5A5);
    tick(1);
    chk("idle_ce_n", 32'(bus.o_SRAM_CE_N), 1);
    chk("idle_dq_z", 32'(dq_idle()), 1);
    chk("idle_addr", 32'(bus.o_SRAM_ADDR), 32'h5);

    // read-back, plus a request during R0 that must be ignored
    chk("rd_ready0", 32'(bus.o_rd_ready), 1);
    rdq.push_back(16'hA5A5);
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = 20'h00005;
    tick(1);
    bus.i_rd_addr = 20'h00009;
    chk("r0_oe_n", 32'(bus.o_SRAM_OE_N), 0);
    chk("r0_we_n", 32'(bus.o_SRAM_WE_N), 1);
    chk("r0_ready", 32'(bus.o_rd_ready), 0);
    chk("r0_addr", 32'(bus.o_SRAM_ADDR), 32'h5);
    tick(1);
    bus.i_rd_req = 1'b0;
    chk("r1_oe_n", 32'(bus.o_SRAM_OE_N), 0);
    chk("r1_valid", 32'(bus.o_rd_valid), 0);
    tick(1);
    chk("rv_valid", 32'(bus.o_rd_valid), 1);
    chk("rv_data", 32'(bus.o_rd_data), 32'hA5A5);
    tick(1);
    chk("rv_pulse", 32'(bus.o_rd_valid), 0);
    chk("rv_hold", 32'(bus.o_rd_data), 32'hA5A5);
    tick(6);
    chk("ignored_rd", 32'(bus.o_SRAM_CE_N), 1);

    // vector table: write then read
    for (int i = 0; i < 4; i++) begin
      pulse_wr(tbl[i].waddr, tbl[i].wdata);
      wait_wr(10);
      pulse_rd(tbl[i].raddr, tbl[i].rexp);
      wait_rd(10);
      chk("tbl_rd", 32'(bus.o_rd_data), 32'(tbl[i].rexp));
      tick(2);
    end

    // back-to-back writes: one IDLE cycle between them
    wrq.push_back('{a: 20'h0003A, d: 16'h3A3A});
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 20'h0003A;
    bus.i_wr_data  = 16'h3A3A;
    tick(1);
    wrq.push_back('{a: 20'h0003B, d: 16'h3B3B});
    bus.i_wr_addr = 20'h0003B;
    bus.i_wr_data = 16'h3B3B;
    tick(1);
    bus.i_wr_valid = 1'b0;
    chk("b2b_w0a", 32'(bus.o_SRAM_WE_N), 0);
    tick(2);
    chk("b2b_idle", 32'(bus.o_SRAM_CE_N), 1);
    tick(1);
    chk("b2b_w0b", 32'(bus.o_SRAM_WE_N), 0);
    chk("b2b_addr", 32'(bus.o_SRAM_ADDR), 32'h3B);
    wait_wr(10);
    tick(3);

    // collision, FIFO empty: read first, returns old content
    wrq.push_back('{a: 20'h00007, d: 16'h2222});
    rdq.push_back(16'h1111);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 20'h00007;
    bus.i_wr_data  = 16'h2222;
    bus.i_rd_req   = 1'b1;
    bus.i_rd_addr  = 20'h00007;
    tick(1);
    bus.i_wr_valid = 1'b0;
    bus.i_rd_req   = 1'b0;
    chk("col_r0", 32'(bus.o_SRAM_OE_N), 0);
    chk("col_we_n", 32'(bus.o_SRAM_WE_N), 1);
    tick(3);
    chk("col_w0", 32'(bus.o_SRAM_WE_N), 0);
    chk("col_waddr", 32'(bus.o_SRAM_ADDR), 32'h7);
    wait_wr(10);
    wait_rd(10);
    chk("col_old", 32'(bus.o_rd_data), 32'h1111);
    tick(2);
    pulse_rd(20'h00007, 16'h2222);
    wait_rd(10);
    tick(3);

    // overflow: 7 writes on consecutive cycles, reads at
    // cycle 0 (FIFO empty) and cycle 6 (FIFO full)
    for (int k = 0; k < 7; k++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr  = 20'h00100 + 20'(k);
      bus.i_wr_data  = 16'hC000 + 16'(k);
      if (k != 5)
        wrq.push_back('{a: 20'h00100 + 20'(k),
                        d: 16'hC000 + 16'(k)});
      bus.i_rd_req  = (k == 0) || (k == 6);
      bus.i_rd_addr = (k == 0) ? 20'h00030 : 20'h00031;
      if (k == 0) rdq.push_back(16'hBEEF);
      if (k == 6) rdq.push_back(16'hCAFE);
      if (k == 5) begin
        chk("ovf_level", 32'(bus.o_fifo_level), 4);
        chk("ovf_pre", 32'(bus.o_overflow), 0);
      end
      if (k == 6) begin
        chk("ovf_set", 32'(bus.o_overflow), 1);
        chk("ovf_sat", 32'(bus.o_fifo_level), 4);
        chk("ovf_ready", 32'(bus.o_rd_ready), 1);
      end
      tick(1);
    end
    bus.i_wr_valid = 1'b0;
    bus.i_rd_req   = 1'b0;
    chk("full_wfirst", 32'(bus.o_SRAM_WE_N), 0);
    chk("full_oe_n", 32'(bus.o_SRAM_OE_N), 1);
    chk("full_addr", 32'(bus.o_SRAM_ADDR), 32'h101);
    wait_wr(80);
    wait_rd(80);
    chk("ovf_sticky", 32'(bus.o_overflow), 1);
    chk("ovf_drain", 32'(bus.o_fifo_level), 0);
    tick(3);

    // reset during W0 aborts and discards the queue
    wrq.push_back('{a: 20'h0003C, d: 16'h7E7E});
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 20'h0003C;
    bus.i_wr_data  = 16'h7E7E;
    tick(1);
    bus.i_wr_addr = 20'h0003D;
    bus.i_wr_data = 16'h7F7F;
    tick(1);
    bus.i_wr_valid = 1'b0;
    chk("mr_w0", 32'(bus.o_SRAM_WE_N), 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mr_we_n", 32'(bus.o_SRAM_WE_N), 1);
    chk("mr_ce_n", 32'(bus.o_SRAM_CE_N), 1);
    chk("mr_dq_z", 32'(dq_idle()), 1);
    chk("mr_level", 32'(bus.o_fifo_level), 0);
    chk("mr_ovf", 32'(bus.o_overflow), 0);
    chk("mr_ready", 32'(bus.o_rd_ready), 1);
    wrq.delete();
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.o_SRAM_CE_N !== 1'b1) strobes++;
    end
    chk("mr_quiet", strobes, 0);

    // recorder-rate stream
    for (int i = 0; i < 10; i++) begin
      pulse_wr(20'(i), 16'h5A00 + 16'(i));
      tick(39);
    end
    wait_wr(20);
    chk("str_ovf", 32'(bus.o_overflow), 0);
    chk("str_level", 32'(bus.o_fifo_level), 0);
    chk("str_rd_none", rdq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
